// File: rtl/watch_pkg.sv
// watch_pkg: shared clock rate, mode index constants and default idle timeout for the watch top level.
package watch_pkg;
  localparam int unsigned IN_CLK_HZ        = 50_000_000;
  localparam int unsigned MODE_WATCH       = 0;
  localparam int unsigned MODE_STOPWATCH   = 1;
  localparam int unsigned MODE_ALARM       = 2;
  localparam int unsigned IDLE_CYCLES_DFLT = 30 * IN_CLK_HZ;
endpackage

// File: rtl/watch_idle_timer.sv
// watch_idle_timer: idle counter with synchronous clear and a combinational expire flag at CYCLES-1.
module watch_idle_timer #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_expire
);
  localparam int unsigned CW = $clog2(CYCLES);
  logic [CW-1:0] r_cnt;
  // Activity in the expiry cycle wins over the return.
  assign o_expire = ~i_clr & (r_cnt == CW'(CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= (i_clr | o_expire) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: NUM_MODES-way mode selector with long-press mode change and per-mode key routing.
// Define WATCH_IDLE_RETURN_EN to return to mode 0 after IDLE_CYCLES idle clocks.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned NUM_MODES   = 2,
  parameter int unsigned NUM_KEYS    = 2,
  parameter int unsigned MODE_KEY    = 0,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DFLT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYS-1:0]           i_key_first,
  input  logic [NUM_KEYS-1:0]           i_key_long,
  input  logic [NUM_MODES-1:0]          i_mode_busy,
  output logic [$clog2(NUM_MODES)-1:0]  o_mode_idx,
  output logic [NUM_MODES-1:0]          o_mode_onehot,
  output logic [NUM_MODES*NUM_KEYS-1:0] o_ev_first,
  output logic [NUM_MODES*NUM_KEYS-1:0] o_ev_long,
  output logic                          o_mode_changed,
  output logic                          o_mode_led
);
  localparam int unsigned MW = $clog2(NUM_MODES);
  localparam int unsigned EW = NUM_MODES * NUM_KEYS;
  if (NUM_MODES < 2 || NUM_KEYS < 1 || MODE_KEY >= NUM_KEYS || IDLE_CYCLES < 2) begin : g_bad_cfg
    $error("watch_mode_ctrl: illegal parameter combination");
  end
  logic [MW-1:0]       r_mode_idx, w_mode_nxt;
  logic [NUM_MODES-1:0] r_mode_onehot;
  logic [EW-1:0]       r_ev_first, r_ev_long, w_ef_nxt, w_el_nxt;
  logic                r_mode_changed, r_mode_led, r_long_q;
  logic                w_busy, w_trig, w_adv, w_exp;
  logic [NUM_KEYS-1:0] w_kl;
  assign w_busy = i_mode_busy[r_mode_idx];
  assign w_trig = i_key_long[MODE_KEY] & ~r_long_q;
  assign w_adv  = w_trig & ~w_busy;
`ifdef WATCH_IDLE_RETURN_EN
  watch_idle_timer #(.CYCLES(IDLE_CYCLES)) u_idle (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    ((|i_key_first) | (|i_key_long) | w_busy | (r_mode_idx == MW'(MODE_WATCH))),
    .o_expire (w_exp)
  );
`else
  assign w_exp = 1'b0;
`endif
  // The mode key's long press reaches a mode only as an edge while that mode is busy.
  always_comb begin
    w_kl           = i_key_long;
    w_kl[MODE_KEY] = w_trig & w_busy;
    w_ef_nxt       = w_adv ? '0 : (EW'(i_key_first) << (r_mode_idx * NUM_KEYS));
    w_el_nxt       = w_adv ? '0 : (EW'(w_kl) << (r_mode_idx * NUM_KEYS));
    w_mode_nxt     = w_adv ? ((r_mode_idx == MW'(NUM_MODES - 1)) ? '0 : r_mode_idx + 1'b1)
                   : w_exp ? MW'(MODE_WATCH) : r_mode_idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mode_idx     <= '0;
      r_mode_onehot  <= NUM_MODES'(1);
      r_ev_first     <= '0;
      r_ev_long      <= '0;
      r_mode_changed <= 1'b0;
      r_mode_led     <= 1'b0;
      r_long_q       <= 1'b0;
    end else begin
      r_mode_idx     <= w_mode_nxt;
      r_mode_onehot  <= NUM_MODES'(1) << w_mode_nxt;
      r_ev_first     <= w_ef_nxt;
      r_ev_long      <= w_el_nxt;
      r_mode_changed <= w_adv | w_exp;
      r_mode_led     <= w_mode_nxt != MW'(MODE_WATCH);
      r_long_q       <= i_key_long[MODE_KEY];
    end
  assign o_mode_idx     = r_mode_idx;
  assign o_mode_onehot  = r_mode_onehot;
  assign o_ev_first     = r_ev_first;
  assign o_ev_long      = r_ev_long;
  assign o_mode_changed = r_mode_changed;
  assign o_mode_led     = r_mode_led;
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb_watch_mode_ctrl: directed and random stimulus against a cycle-level behavioural model of the mode controller.
module tb_watch_mode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_first, key_long;
  logic [2:0] mode_busy;
  logic [1:0] mode_idx;
  logic [2:0] mode_onehot;
  logic [5:0] ev_first, ev_long;
  logic       mode_changed, mode_led;
  int errors = 0;
  int checks = 0;
  int m_mode, m_cnt, e_ef, e_el, e_chg;
  bit m_prev;
  watch_mode_ctrl #(.NUM_MODES(3), .NUM_KEYS(2), .MODE_KEY(0), .IDLE_CYCLES(100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_key_first    (key_first),
    .i_key_long     (key_long),
    .i_mode_busy    (mode_busy),
    .o_mode_idx     (mode_idx),
    .o_mode_onehot  (mode_onehot),
    .o_ev_first     (ev_first),
    .o_ev_long      (ev_long),
    .o_mode_changed (mode_changed),
    .o_mode_led     (mode_led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".idx"}, 32'(mode_idx), 32'(m_mode));
    chk({tag, ".onehot"}, 32'(mode_onehot), 32'(1 << m_mode));
    chk({tag, ".ev_first"}, 32'(ev_first), 32'(e_ef));
    chk({tag, ".ev_long"}, 32'(ev_long), 32'(e_el));
    chk({tag, ".changed"}, 32'(mode_changed), 32'(e_chg));
    chk({tag, ".led"}, 32'(mode_led), 32'(m_mode != 0));
  endtask
  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_prev = 0; e_ef = 0; e_el = 0; e_chg = 0;
  endtask
  task automatic step(input logic [1:0] kf, input logic [1:0] kl, input logic [2:0] busy, input string tag);
    bit trig, b, clr;
    int old;
    key_first = kf; key_long = kl; mode_busy = busy;
    trig = kl[0] && !m_prev;
    m_prev = kl[0];
    old = m_mode;
    b = busy[old];
    e_chg = 0; e_ef = 0; e_el = 0;
    if (trig && !b) begin
      m_mode = (m_mode + 1) % 3;
      e_chg = 1;
    end else begin
      e_ef = int'(kf) << (old * 2);
      e_el = int'({kl[1], trig && b}) << (old * 2);
    end
`ifdef WATCH_IDLE_RETURN_EN
    clr = kf != 0 || kl != 0 || b || old == 0;
    if (clr) m_cnt = 0;
    else if (m_cnt == 99) begin m_mode = 0; e_chg = 1; m_cnt = 0; end
    else m_cnt++;
`else
    clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    logic [1:0] kl_r;
    rst_n = 1'b0; key_first = '0; key_long = '0; mode_busy = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 2'b01, 3'b000, "cycle");
      step(2'b00, 2'b00, 3'b000, "cycle_rel");
    end
    repeat (10) step(2'b00, 2'b01, 3'b000, "hold");
    step(2'b00, 2'b00, 3'b000, "hold_rel");
    chk("hold_once", 32'(mode_idx), 32'd1);
    step(2'b10, 2'b00, 3'b000, "route");
    chk("route_bit3", 32'(ev_first), 32'b001000);
    step(2'b00, 2'b00, 3'b000, "route_end");
    step(2'b00, 2'b01, 3'b000, "to2");
    step(2'b00, 2'b00, 3'b000, "to2_rel");
    step(2'b00, 2'b01, 3'b100, "busy");
    chk("busy_bit4", 32'(ev_long), 32'b010000);
    chk("busy_stay", 32'(mode_idx), 32'd2);
    step(2'b00, 2'b00, 3'b100, "busy_rel");
    step(2'b10, 2'b01, 3'b000, "simul");
    chk("simul_noev", 32'(ev_first), 32'd0);
    step(2'b00, 2'b00, 3'b000, "simul_rel");
    step(2'b00, 2'b01, 3'b000, "pre_rst");
    step(2'b00, 2'b00, 3'b000, "pre_rst");
    step(2'b00, 2'b01, 3'b000, "pre_rst");
    step(2'b00, 2'b00, 3'b000, "pre_rst");
    chk("pre_rst_mode", 32'(mode_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_oh", 32'(mode_onehot), 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 2'b01, 3'b000, "idle_to1");
    repeat (99) step(2'b00, 2'b00, 3'b000, "idle");
    step(2'b10, 2'b00, 3'b000, "idle_kill");
    chk("idle_kill_mode", 32'(mode_idx), 32'd1);
    repeat (1000) step(2'b00, 2'b00, 3'b000, "idle_long");
`ifdef WATCH_IDLE_RETURN_EN
    chk("idle_final", 32'(mode_idx), 32'd0);
`else
    chk("idle_final", 32'(mode_idx), 32'd1);
`endif
    kl_r = '0;
    repeat (400) begin
      kl_r[0] = ($urandom_range(0, 3) == 0) ? ~kl_r[0] : kl_r[0];
      kl_r[1] = ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, kl_r,
           3'($urandom) & 3'($urandom), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
